axis_be2le_skid_bridge: RTL and testbench
=========================================

// Module: axis_be2le_skid_bridge
// PURPOSE
//  Big-endian to little-endian AXI4-Stream bridge; returns wt_unit/SHA2 core output to the NetFPGA datapath.
//  Reverses byte order of tdata and bit order of tkeep per beat, passing tuser/tlast unchanged.
//  Registered through a 2-entry skid buffer: full throughput, no combinational ready/valid paths.
//  Counts beats and packets for host-visible status.
// PARAMETERS
//  C_AXIS_DATA_WIDTH   512  tdata width in bits; multiple of 8
//  C_AXIS_TUSER_WIDTH  128  tuser width in bits
//  C_CNT_WIDTH         32   width of pkt_count / beat_count
// PORTS
//  clk            in   1       core clock
//  reset          in   1       reset, synchronous, active-high
//  s_axis_tdata   in   DW      big-endian data (byte 0 = bits [DW-1:DW-8])
//  s_axis_tkeep   in   DW/8    big-endian keep (bit DW/8-1 = first byte)
//  s_axis_tuser   in   UW      sideband, passed through
//  s_axis_tvalid  in   1       input beat valid
//  s_axis_tready  out  1       buffer can accept a beat
//  s_axis_tlast   in   1       last beat of packet
//  m_axis_tdata   out  DW      little-endian data
//  m_axis_tkeep   out  DW/8    little-endian keep
//  m_axis_tuser   out  UW      sideband
//  m_axis_tvalid  out  1       output beat valid
//  m_axis_tready  in   1       downstream ready
//  m_axis_tlast   out  1       last beat of packet
//  pkt_count      out  CW     packets completed on master side (tlast handshakes)
//  beat_count     out  CW     beats of current slave-side packet accepted so far
//  keep_err       out  1      sticky: non-contiguous tkeep seen (see CONFIGURATION)
// BEHAVIOUR
//  - Mapping, per beat: m_tdata[8i+7:8i] = s_tdata[DW-8i-1:DW-8i-8]; m_tkeep[i] = s_tkeep[DW/8-1-i].
//  - Swap occurs on the slave-side write into the buffer; stored entries are already little-endian.
//  - Handshake: accept on s_tvalid&s_tready; send on m_tvalid&m_tready. m_* held stable while m_tvalid&!m_tready.
//  - FSM: EMPTY (0 entries), ONE (1), TWO (2). s_axis_tready = registered (state!=TWO); m_axis_tvalid = (state!=EMPTY).
//    EMPTY: push -> ONE.  ONE: push&!pop -> TWO; pop&!push -> EMPTY; push&pop -> ONE (new beat to output reg).
//    TWO: pop -> ONE, skid entry moves to output register; push impossible (tready=0).
//  - Latency: 1 cycle from input handshake to m_tvalid when EMPTY. Sustains 1 beat/cycle with m_tready held high.
//  - Beat ordering strictly preserved; no beat dropped or duplicated across TWO->ONE transitions.
//  - beat_count: +1 per accepted beat; cleared to 0 on the cycle after an accepted tlast beat.
//    Saturates at all-ones (no wrap).
//  - pkt_count: +1 per output handshake with tlast; wraps modulo 2^CW.
//  - Reset (any time, incl. mid-packet): state=EMPTY, s_tready=0 during reset then 1, m_tvalid=0, m_tdata/tkeep/tuser/tlast=0,
//    counters=0, keep_err=0. Buffered beats are discarded; no partial-packet recovery.
//  - tkeep=0 beats are passed through unchanged (still counted).
// CONFIGURATION
//  - Macro BE2LE_KEEP_CHECK_EN. Defined: on each accepted beat, big-endian s_tkeep must be a contiguous run
//    of 1s starting at MSB (all-ones on non-last beats); violation sets keep_err the next cycle, sticky until reset.
//    Data still forwarded unmodified.
//  - Undefined: checker logic not compiled; keep_err tied to 0.
// STRUCTURE
//  - Shared package/header: FSM state localparams (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2) and the log2 function
//    used across wt_unit bridges.
//  - One sub-module: axis_skid_buffer (width-parametric 2-entry registered buffer, payload = {tuser,tlast,tkeep,tdata});
//    byte-swap, counters and checker stay in the top.
// TESTING (bench at DW=64, UW=8, CW=8)
//  - Single beat tdata=64'h0102030405060708, tkeep=8'hFF, tlast=1, m_tready=1 -> next cycle m_tdata=64'h0807060504030201,
//    m_tkeep=8'hFF, m_tlast=1; pkt_count=1.
//  - Last beat tkeep=8'hE0 (3 first bytes) -> m_tkeep=8'h07; with BE2LE_KEEP_CHECK_EN keep_err stays 0.
//  - 10-beat packet, m_tready=1 -> one beat/cycle, s_tready never drops; beat_count 1..10 then 0; pkt_count=1.
//  - m_tready low 3 cycles during stream -> s_tready drops after 2 buffered beats; on release all beats emerge
//    in order, m_* stable while stalled.
//  - tkeep=8'hA0 with BE2LE_KEEP_CHECK_EN -> keep_err=1 next cycle and sticky; without macro keep_err=0.
//  - reset asserted with 2 beats buffered -> m_tvalid=0, counters=0 next cycle; following packet passes cleanly.

Source files
------------

// File: rtl/axis_be2le_skid_bridge_pkg.sv
// Shared definitions for the wt_unit stream bridges: skid-buffer FSM states and a log2 helper.
package axis_be2le_skid_bridge_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    // Ceiling log2, returns 0 for values of 0 or 1.
    function automatic int log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer: output register plus one skid register, ready is a flop.
module axis_skid_buffer
    import axis_be2le_skid_bridge_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [PW-1:0] i_s_data,
    input  logic          i_s_valid,
    output logic          o_s_ready,
    output logic [PW-1:0] o_m_data,
    output logic          o_m_valid,
    input  logic          i_m_ready
);

    skid_state_t   r_state;
    skid_state_t   w_next;
    logic [PW-1:0] r_out;
    logic [PW-1:0] r_skid;
    logic          r_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_load_out_in;
    logic          w_load_out_skid;
    logic          w_load_skid;

    // A beat moves on valid&ready at each side; ready is registered so no input-to-ready path exists.
    assign w_push = i_s_valid & r_ready;
    assign w_pop  = (r_state != ST_EMPTY) & i_m_ready;

    always_comb begin
        w_next          = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_next        = ST_ONE;
                    w_load_out_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_push && !w_pop) begin
                    w_next      = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_pop && !w_push) begin
                    w_next = ST_EMPTY;
                end else if (w_push && w_pop) begin
                    w_load_out_in = 1'b1;
                end
            end
            ST_TWO: begin
                if (w_pop) begin
                    w_next          = ST_ONE;
                    w_load_out_skid = 1'b1;
                end
            end
            default: begin
                w_next = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_out   <= '0;
            r_skid  <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next != ST_TWO);
            if (w_load_out_in) begin
                r_out <= i_s_data;
            end else if (w_load_out_skid) begin
                r_out <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_s_data;
            end
        end
    end

    assign o_s_ready = r_ready;
    assign o_m_data  = r_out;
    assign o_m_valid = (r_state != ST_EMPTY);

endmodule

// File: rtl/axis_be2le_skid_bridge.sv
// Big-endian to little-endian AXI4-Stream bridge with 2-entry skid buffer and status counters.
// Optional tkeep contiguity checker enabled by defining BE2LE_KEEP_CHECK_EN.
module axis_be2le_skid_bridge
    import axis_be2le_skid_bridge_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 512,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_CNT_WIDTH        = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [C_CNT_WIDTH-1:0]          pkt_count,
    output logic [C_CNT_WIDTH-1:0]          beat_count,
    output logic                            keep_err
);

    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int KW = C_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_AXIS_TUSER_WIDTH;
    localparam int CW = C_CNT_WIDTH;
    localparam int PW = UW + 1 + KW + DW;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [DW-1:0] w_le_data;
    logic [KW-1:0] w_le_keep;
    logic [PW-1:0] w_s_payload;
    logic [PW-1:0] w_m_payload;
    logic          w_s_hs;
    logic          w_m_hs;
    logic [CW-1:0] r_beat_count;
    logic          r_beat_clr;
    logic [CW-1:0] r_pkt_count;

    // Swap happens before the buffer, so both stored entries are already little-endian.
    always_comb begin
        w_le_data = '0;
        w_le_keep = '0;
        for (int i = 0; i < KW; i++) begin
            w_le_data[8*i +: 8] = s_axis_tdata[DW-8*i-8 +: 8];
            w_le_keep[i]        = s_axis_tkeep[KW-1-i];
        end
    end

    assign w_s_payload = {s_axis_tuser, s_axis_tlast, w_le_keep, w_le_data};

    axis_skid_buffer #(
        .PW (PW)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .i_s_data  (w_s_payload),
        .i_s_valid (s_axis_tvalid),
        .o_s_ready (s_axis_tready),
        .o_m_data  (w_m_payload),
        .o_m_valid (m_axis_tvalid),
        .i_m_ready (m_axis_tready)
    );

    assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = w_m_payload;

    assign w_s_hs = s_axis_tvalid & s_axis_tready;
    assign w_m_hs = m_axis_tvalid & m_axis_tready;

    // beat_count shows the final beat number for one cycle after tlast, then restarts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat_count <= '0;
            r_beat_clr   <= 1'b0;
            r_pkt_count  <= '0;
        end else begin
            r_beat_clr <= w_s_hs & s_axis_tlast;
            if (r_beat_clr) begin
                r_beat_count <= w_s_hs ? CNT_ONE : '0;
            end else if (w_s_hs && (r_beat_count != {CW{1'b1}})) begin
                r_beat_count <= r_beat_count + CNT_ONE;
            end
            if (w_m_hs && m_axis_tlast) begin
                r_pkt_count <= r_pkt_count + CNT_ONE;
            end
        end
    end

    assign beat_count = r_beat_count;
    assign pkt_count  = r_pkt_count;

`ifdef BE2LE_KEEP_CHECK_EN
    logic r_keep_err;
    logic w_keep_bad;

    // In little-endian order a legal last-beat keep is 0..01..1, i.e. keep & (keep+1) == 0.
    always_comb begin
        w_keep_bad = 1'b0;
        if (s_axis_tlast) begin
            w_keep_bad = ((w_le_keep & (w_le_keep + {{(KW-1){1'b0}}, 1'b1})) != '0);
        end else begin
            w_keep_bad = (s_axis_tkeep != {KW{1'b1}});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_keep_err <= 1'b0;
        end else if (w_s_hs && w_keep_bad) begin
            r_keep_err <= 1'b1;
        end
    end

    assign keep_err = r_keep_err;
`else
    assign keep_err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_be2le_skid_bridge.sv
// Directed bench for axis_be2le_skid_bridge at DW=64, UW=8, CW=8.
module tb_axis_be2le_skid_bridge;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int UW = 8;
    localparam int CW = 8;
    localparam int PW = UW + 1 + KW + DW;

`ifdef BE2LE_KEEP_CHECK_EN
    localparam logic EXP_KEEP_ERR = 1'b1;
`else
    localparam logic EXP_KEEP_ERR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic [UW-1:0] s_axis_tuser = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] beat_count;
    logic          keep_err;

    axis_be2le_skid_bridge #(
        .C_AXIS_DATA_WIDTH  (DW),
        .C_AXIS_TUSER_WIDTH (UW),
        .C_CNT_WIDTH        (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .pkt_count     (pkt_count),
        .beat_count    (beat_count),
        .keep_err      (keep_err)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    int exp_pkt = 0;
    logic [PW-1:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] swap_data(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        for (int i = 0; i < KW; i++) r[8*i +: 8] = d[DW-8-8*i +: 8];
        return r;
    endfunction

    function automatic logic [KW-1:0] swap_keep(input logic [KW-1:0] k);
        logic [KW-1:0] r;
        for (int i = 0; i < KW; i++) r[i] = k[KW-1-i];
        return r;
    endfunction

    // Output monitor: compares every output handshake with the queue and checks stall stability.
    logic [PW-1:0] prev_payload = '0;
    logic          prev_stall = 1'b0;
    always @(negedge clk) begin
        logic [PW-1:0] cur;
        logic [PW-1:0] exp;
        cur = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        if (reset) begin
            exp_pkt = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {127'd0, m_axis_tvalid}, 128'd1);
                check("stall_payload", {{(128-PW){1'b0}}, cur}, {{(128-PW){1'b0}}, prev_payload});
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {{(128-PW){1'b0}}, cur}, 128'd0);
                    errors += (cur == '0) ? 1 : 0;
                end else begin
                    exp = exp_q.pop_front();
                    check("out_beat", {{(128-PW){1'b0}}, cur}, {{(128-PW){1'b0}}, exp});
                    if (exp[DW+KW]) exp_pkt++;
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_payload = cur;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic [UW-1:0] u,
                             input logic last, input logic [DW-1:0] exp_d, input logic [KW-1:0] exp_k);
        logic accepted;
        int   n;
        exp_q.push_back({u, last, exp_k, exp_d});
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tuser  = u;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        accepted = 1'b0;
        n = 0;
        while (!accepted && n < 50) begin
            accepted = s_axis_tready;
            tick();
            n++;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no s_axis_tready expected ready within 50 cycles");
        end
    endtask

    task automatic idle_inputs();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 50) begin
            tick();
            n++;
        end
        tick();
        check("drain_queue_empty", exp_q.size(), 128'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic [DW-1:0] exp_d;
        logic [KW-1:0] exp_k;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'h0102030405060708, 8'hFF, 8'h11, 64'h0807060504030201, 8'hFF};
        vecs[1] = '{64'hA1B2C3D4E5F60718, 8'hE0, 8'h22, 64'h1807F6E5D4C3B2A1, 8'h07};
        vecs[2] = '{64'hDEADBEEFCAFEF00D, 8'h00, 8'h33, 64'h0DF0FECAEFBEADDE, 8'h00};
        vecs[3] = '{64'h1122334455667788, 8'hC0, 8'h44, 64'h8877665544332211, 8'h03};
        vecs[4] = '{64'hFFEEDDCCBBAA9988, 8'h80, 8'h55, 64'h8899AABBCCDDEEFF, 8'h01};

        // Reset state
        tick();
        tick();
        check("rst_tready", {127'd0, s_axis_tready}, 128'd0);
        check("rst_tvalid", {127'd0, m_axis_tvalid}, 128'd0);
        check("rst_tdata", {64'd0, m_axis_tdata}, 128'd0);
        check("rst_pkt", {120'd0, pkt_count}, 128'd0);
        check("rst_beat", {120'd0, beat_count}, 128'd0);
        check("rst_keep_err", {127'd0, keep_err}, 128'd0);
        reset = 1'b0;
        tick();
        check("post_rst_tready", {127'd0, s_axis_tready}, 128'd1);

        // Single-beat packets from the table, one cycle latency to output
        for (int i = 0; i < 5; i++) begin
            send_beat(vecs[i].d, vecs[i].k, vecs[i].u, 1'b1, vecs[i].exp_d, vecs[i].exp_k);
            idle_inputs();
            check("vec_tvalid", {127'd0, m_axis_tvalid}, 128'd1);
            check("vec_tdata", {64'd0, m_axis_tdata}, {64'd0, vecs[i].exp_d});
            check("vec_tkeep", {120'd0, m_axis_tkeep}, {120'd0, vecs[i].exp_k});
            check("vec_beat_count", {120'd0, beat_count}, 128'd1);
            tick();
            check("vec_pkt_count", {120'd0, pkt_count}, i + 1);
            check("vec_beat_cleared", {120'd0, beat_count}, 128'd0);
        end
        check("vec_keep_err", {127'd0, keep_err}, 128'd0);

        // 10-beat packet at full rate
        for (int i = 0; i < 10; i++) begin
            logic [DW-1:0] d;
            d = {8'(i), 8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4, 8'hF5, 8'(8'h10 + i)};
            send_beat(d, 8'hFF, 8'(i), (i == 9), swap_data(d), 8'hFF);
            check("burst_tready", {127'd0, s_axis_tready}, 128'd1);
            check("burst_beat_count", {120'd0, beat_count}, i + 1);
        end
        idle_inputs();
        tick();
        check("burst_beat_cleared", {120'd0, beat_count}, 128'd0);
        drain();
        check("burst_pkt_count", {120'd0, pkt_count}, 128'd6);

        // Downstream stall: two beats fill the buffer, then release
        m_axis_tready = 1'b0;
        send_beat(64'h1111111111111111, 8'hFF, 8'hA1, 1'b0, 64'h1111111111111111, 8'hFF);
        send_beat(64'h0022446688AACCEE, 8'hFF, 8'hA2, 1'b0, 64'hEECCAA8866442200, 8'hFF);
        idle_inputs();
        check("stall_tready_low", {127'd0, s_axis_tready}, 128'd0);
        tick();
        tick();
        check("stall_tready_still_low", {127'd0, s_axis_tready}, 128'd0);
        check("stall_beat_count", {120'd0, beat_count}, 128'd2);
        check("stall_tvalid", {127'd0, m_axis_tvalid}, 128'd1);
        check("stall_head", {64'd0, m_axis_tdata}, 128'h1111111111111111);
        m_axis_tready = 1'b1;
        send_beat(64'h0123456789ABCDEF, 8'hFF, 8'hA3, 1'b0, 64'hEFCDAB8967452301, 8'hFF);
        send_beat(64'hCAFE000000000000, 8'hC0, 8'hA4, 1'b1, 64'h000000000000FECA, 8'h03);
        idle_inputs();
        drain();
        check("stall_pkt_count", {120'd0, pkt_count}, 128'd7);

        // Non-contiguous keep, then a clean packet: error is sticky when the checker exists
        send_beat(64'h5566778899AABBCC, 8'hA0, 8'hB0, 1'b1, 64'hCCBBAA9988776655, 8'h05);
        idle_inputs();
        check("keep_err_set", {127'd0, keep_err}, {127'd0, EXP_KEEP_ERR});
        send_beat(64'h0102030405060708, 8'hFF, 8'hB1, 1'b1, 64'h0807060504030201, 8'hFF);
        idle_inputs();
        drain();
        check("keep_err_sticky", {127'd0, keep_err}, {127'd0, EXP_KEEP_ERR});
        check("keep_pkt_count", {120'd0, pkt_count}, 128'd9);

        // Reset with two beats buffered
        m_axis_tready = 1'b0;
        send_beat(64'h9999999999999999, 8'hFF, 8'hC1, 1'b0, 64'h9999999999999999, 8'hFF);
        send_beat(64'h7777777777777777, 8'hFF, 8'hC2, 1'b0, 64'h7777777777777777, 8'hFF);
        idle_inputs();
        reset = 1'b1;
        exp_q.delete();
        tick();
        check("mid_rst_tvalid", {127'd0, m_axis_tvalid}, 128'd0);
        check("mid_rst_tready", {127'd0, s_axis_tready}, 128'd0);
        check("mid_rst_pkt", {120'd0, pkt_count}, 128'd0);
        check("mid_rst_beat", {120'd0, beat_count}, 128'd0);
        check("mid_rst_keep_err", {127'd0, keep_err}, 128'd0);
        check("mid_rst_tdata", {64'd0, m_axis_tdata}, 128'd0);
        reset = 1'b0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [DW-1:0] d;
            d = {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'(i)};
            send_beat(d, 8'hFF, 8'(8'hD0 + i), (i == 2), swap_data(d), swap_keep(8'hFF));
        end
        idle_inputs();
        drain();
        check("post_rst_pkt", {120'd0, pkt_count}, 128'd1);
        check("post_rst_mon_pkt", {120'd0, pkt_count}, exp_pkt);
        check("post_rst_beat", {120'd0, beat_count}, 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
